// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch from a combinational ROM into a
// 2-entry {pc, inst} buffer with redirect (flush) and fetch-enable control.
`default_nettype none

module fetch_unit #(
    parameter int          AW       = 10,
    parameter int          DW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_en,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic [AW-1:0] rom_raddr,
    input  logic [DW-1:0] rom_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [DW-1:0] out_inst
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0]   pc;
    logic [31:0]   fifo_pc   [2];
    logic [DW-1:0] fifo_inst [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          pop;
    logic          push;
    logic          unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    // A full buffer can still accept a new fetch when its head leaves this cycle.
    assign push      = fetch_en & ~redirect_valid & ((count != 2'd2) | pop);
    assign rom_raddr = pc[AW+1:2];
    assign out_pc    = fifo_pc[rd_ptr];
    assign out_inst  = fifo_inst[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= RESET_PC_ALIGNED;
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            fifo_pc[0]   <= '0;
            fifo_pc[1]   <= '0;
            fifo_inst[0] <= '0;
            fifo_inst[1] <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle pop or push.
            pc     <= {redirect_pc[31:2], 2'b00};
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= pc;
                fifo_inst[wr_ptr] <= rom_rdata;
                wr_ptr            <= ~wr_ptr;
                pc                <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized stimulus against a queue-based reference model,
// with directed sequences whose outputs are pinned to hand-computed literals.
`default_nettype none

module tb_fetch_unit;

    localparam int          AW       = 10;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [AW-1:0] rom_raddr;
    logic [DW-1:0] rom_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [DW-1:0] out_inst;

    always #5 clk = ~clk;

    fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rom_raddr      (rom_raddr),
        .rom_rdata      (rom_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    logic [DW-1:0] rom_mem [1 << AW];
    assign rom_rdata = rom_mem[rom_raddr];

    // Reference model: the buffer is just a queue of fetched entries.
    typedef struct {
        logic [31:0]   pc;
        logic [DW-1:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;

    int n_checks = 0;
    int n_fail   = 0;

    // Literal expectations for the state visible during the current cycle.
    logic [3:0]    pin_mask = 4'b0;
    string         pin_name = "";
    logic          pin_valid;
    logic [31:0]   pin_pc;
    logic [DW-1:0] pin_inst;
    logic [AW-1:0] pin_raddr;

    task automatic model_reset();
        q.delete();
        mpc = {RESET_PC[31:2], 2'b00};
    endtask

    task automatic model_step();
        bit pop;
        bit push;
        int n;
        if (!rst_n) begin
            model_reset();
        end else begin
            n   = q.size();
            pop = (n != 0) && out_ready;
            if (redirect_valid) begin
                q.delete();
                mpc = {redirect_pc[31:2], 2'b00};
            end else begin
                push = fetch_en && ((n < 2) || pop);
                if (pop) void'(q.pop_front());
                if (push) begin
                    q.push_back('{mpc, rom_mem[mpc[AW+1:2]]});
                    mpc = mpc + 32'd4;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset out_valid", {31'b0, out_valid}, 32'd0);
            chk("reset out_pc", out_pc, 32'd0);
            chk("reset out_inst", out_inst, 32'd0);
            chk("reset rom_raddr", {{(32-AW){1'b0}}, rom_raddr},
                {{(32-AW){1'b0}}, RESET_PC[AW+1:2]});
        end else begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, (q.size() != 0)});
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_inst", out_inst, q[0].inst);
            end
            chk("rom_raddr", {{(32-AW){1'b0}}, rom_raddr},
                {{(32-AW){1'b0}}, mpc[AW+1:2]});
        end
        if (pin_mask[0]) chk({pin_name, " valid"}, {31'b0, out_valid}, {31'b0, pin_valid});
        if (pin_mask[1]) chk({pin_name, " pc"}, out_pc, pin_pc);
        if (pin_mask[2]) chk({pin_name, " inst"}, out_inst, pin_inst);
        if (pin_mask[3]) chk({pin_name, " raddr"}, {{(32-AW){1'b0}}, rom_raddr},
                             {{(32-AW){1'b0}}, pin_raddr});
    end

    task automatic pin(input string name, input logic [3:0] mask, input logic v,
                       input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] ra);
        pin_name  = name;
        pin_mask  = mask;
        pin_valid = v;
        pin_pc    = pc;
        pin_inst  = inst;
        pin_raddr = ra[AW-1:0];
    endtask

    task automatic cyc(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        model_step();
        #1;
        pin_mask = 4'b0;
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        model_reset();
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) rom_mem[i] = 32'h100 + i;
        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming from reset, one instruction per cycle.
        pin("start", 4'b1001, 1'b0, 0, 0, 0);          cyc(1, 0, 0, 1);
        pin("stream0", 4'b0111, 1'b1, 0, 32'h100, 0);  cyc(1, 0, 0, 1);
        pin("stream1", 4'b0111, 1'b1, 4, 32'h101, 0);  cyc(1, 0, 0, 1);
        pin("stream2", 4'b0111, 1'b1, 8, 32'h102, 0);  cyc(1, 0, 0, 1);

        // Backpressure: buffer fills, pc stops at 8, head holds.
        rst_pulse();
        repeat (5) cyc(1, 0, 0, 0);
        pin("stall", 4'b1011, 1'b1, 0, 0, 2);          cyc(1, 0, 0, 1);
        pin("resume4", 4'b0011, 1'b1, 4, 0, 0);        cyc(1, 0, 0, 1);
        pin("resume8", 4'b0011, 1'b1, 8, 0, 0);        cyc(1, 0, 0, 1);
        pin("resumeC", 4'b0111, 1'b1, 32'hC, 32'h103, 0); cyc(1, 0, 0, 0);

        // Redirect while full.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 32'h203, 0);
        pin("redir0", 4'b1001, 1'b0, 0, 0, 32'h80);    cyc(1, 0, 0, 1);
        pin("redir1", 4'b0111, 1'b1, 32'h200, 32'h180, 0); cyc(1, 0, 0, 1);

        // ROM word-index wrap at 0x1000 and 32-bit pc wrap.
        cyc(1, 1, 32'hFF8, 1);
        pin("wrapA0", 4'b1001, 1'b0, 0, 0, 32'h3FE);   cyc(1, 0, 0, 1);
        pin("wrapA1", 4'b0111, 1'b1, 32'hFF8, 32'h4FE, 0);  cyc(1, 0, 0, 1);
        pin("wrapA2", 4'b0111, 1'b1, 32'hFFC, 32'h4FF, 0);  cyc(1, 0, 0, 1);
        pin("wrapA3", 4'b0111, 1'b1, 32'h1000, 32'h100, 0); cyc(1, 1, 32'hFFFF_FFF8, 1);
        cyc(1, 0, 0, 1);
        pin("wrapB1", 4'b0111, 1'b1, 32'hFFFF_FFF8, 32'h4FE, 0); cyc(1, 0, 0, 1);
        pin("wrapB2", 4'b0111, 1'b1, 32'hFFFF_FFFC, 32'h4FF, 0); cyc(1, 0, 0, 1);
        pin("wrapB3", 4'b0111, 1'b1, 32'h0, 32'h100, 0);         cyc(1, 0, 0, 1);

        // fetch_en toggling every cycle.
        for (int i = 0; i < 20; i++) cyc(i[0], 0, 0, 1);

        // Asynchronous reset with a full buffer, then restart.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        rst_pulse();
        pin("rst_restart0", 4'b1001, 1'b0, 0, 0, 0);           cyc(1, 0, 0, 1);
        pin("rst_restart1", 4'b0111, 1'b1, 0, 32'h100, 0);     cyc(1, 0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] rpc;
            case ($urandom_range(0, 3))
                0:       rpc = 32'hFFFF_FFE0 | $urandom_range(0, 31);
                1:       rpc = 32'h0000_0FE0 | $urandom_range(0, 31);
                default: rpc = $urandom;
            endcase
            if ($urandom_range(0, 399) == 0) begin
                rst_pulse();
            end else begin
                cyc($urandom_range(0, 9) < 8, $urandom_range(0, 29) == 0, rpc,
                    $urandom_range(0, 9) < 6);
            end
        end

        cyc(0, 0, 0, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
